qos_wrr_arbiter: RTL

Parametrised weighted-round-robin QoS arbiter, next generation of the fixed 4-VC QoS conditioner.
- Serves NUM_VC virtual-channel FIFOs (show-ahead outputs) with per-VC programmable weights, downstream pause, and per-round credit reload.
- Sits between the VC FIFOs and the single output link.
- Drives FIFO pops and a registered output word tagged with VC id and weight.

---
 rtl/qos_wrr_arbiter.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/qos_wrr_arbiter.sv
// qos_wrr_arbiter: weighted-round-robin QoS arbiter serving NUM_VC show-ahead
// VC FIFOs onto a single output link. Each VC spends one credit per pop; when
// every eligible VC is out of credit the arbiter takes a RELOAD bubble that
// refills all credits from the programmed weights.
// Optional build macro: QOS_STATS_EN adds per-VC saturating grant counters
// read back through stat_sel / stat_count.
//
// Handshake: req_valid[i] is the FIFO's "valid" and pop[i] is our "ready".
// A word moves on a rising edge where both are high. pop is combinational, is
// one-hot, is only raised for a VC whose req_valid is high in that cycle, and
// the FIFO must advance its head on that same edge. The served word appears on
// data_out with data_valid=1 in the following cycle.
module qos_wrr_arbiter #(
    parameter int NUM_VC         = 4,
    parameter int VC_ID_W        = 2,
    parameter int WEIGHT_W       = 3,
    parameter int DATA_W         = 4,
    parameter int DEFAULT_WEIGHT = 1
) (
    input  logic                       CLK_2MHz,
    input  logic                       reset,
    input  logic [NUM_VC-1:0]          req_valid,
    input  logic [NUM_VC-1:0]          pause,
    input  logic [NUM_VC*DATA_W-1:0]   data_in,
    input  logic                       edit_weight,
    input  logic [VC_ID_W-1:0]         vc_assign,
    input  logic [WEIGHT_W-1:0]        weight_assign,
    output logic [NUM_VC-1:0]          pop,
    output logic [DATA_W-1:0]          data_out,
    output logic                       data_valid,
    output logic [VC_ID_W-1:0]         VC_id,
    output logic [WEIGHT_W-1:0]        weight,
    output logic                       idle,
    output logic                       cfg_error,
`ifdef QOS_STATS_EN
    input  logic [VC_ID_W-1:0]         stat_sel,
    output logic [7:0]                 stat_count,
`endif
    output logic [1:0]                 fsm_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SERVE  = 2'd1,
        RELOAD = 2'd2
    } state_t;

    localparam logic [31:0] NUM_VC_U = 32'(NUM_VC);

    state_t              state_q, state_d;
    logic [VC_ID_W-1:0]  cur_q, cur_d;
    logic [WEIGHT_W-1:0] weight_q [NUM_VC];
    logic [WEIGHT_W-1:0] credit_q [NUM_VC];
    logic [WEIGHT_W-1:0] credit_d [NUM_VC];

    logic [NUM_VC-1:0]   eligible;
    logic [NUM_VC-1:0]   servable;
    logic                any_eligible;
    logic                any_servable;
    logic [VC_ID_W-1:0]  sel;
    logic                pop_en;
    logic                wr_ok;
    logic                wr_bad;

    logic [DATA_W-1:0]   data_q;
    logic                valid_q;
    logic [VC_ID_W-1:0]  vc_q;
    logic [WEIGHT_W-1:0] wout_q;
    logic                cfg_err_q;

    // Per-VC eligibility (wants service, not paused, not disabled) and servability (has credit).
    always_comb begin
        eligible = '0;
        servable = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            eligible[i] = req_valid[i] & ~pause[i] & (weight_q[i] != '0);
            servable[i] = eligible[i] & (credit_q[i] != '0);
        end
    end

    assign any_eligible = |eligible;
    assign any_servable = |servable;

    // Selection: stay on cur while it can burst, else first servable VC after cur (wrapping).
    always_comb begin
        logic found;
        int   idx;
        sel   = cur_q;
        found = servable[cur_q];
        idx   = 0;
        for (int k = 1; k < NUM_VC; k++) begin
            idx = (int'(cur_q) + k) % NUM_VC;
            if (!found && servable[idx]) begin
                sel   = VC_ID_W'(idx);
                found = 1'b1;
            end
        end
    end

    // Weight write decode; an out-of-range VC index is rejected and flagged.
    assign wr_ok  = edit_weight && (32'(vc_assign) <  NUM_VC_U);
    assign wr_bad = edit_weight && (32'(vc_assign) >= NUM_VC_U);

    // FSM next state, credit accounting and round pointer.
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        pop_en  = 1'b0;
        for (int i = 0; i < NUM_VC; i++) begin
            credit_d[i] = credit_q[i];
        end
        case (state_q)
            IDLE: begin
                if (any_servable) begin
                    state_d = SERVE;
                end else if (any_eligible) begin
                    state_d = RELOAD;
                end
            end
            SERVE: begin
                if (any_servable) begin
                    pop_en        = 1'b1;
                    credit_d[sel] = credit_q[sel] - WEIGHT_W'(1);
                    cur_d         = sel;
                end else if (any_eligible) begin
                    state_d = RELOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            RELOAD: begin
                // Reload uses the weights as they stand before this edge, so a
                // same-cycle weight write only counts from the next round.
                for (int i = 0; i < NUM_VC; i++) begin
                    credit_d[i] = weight_q[i];
                end
                // Step past the VC that closed the round so its neighbour goes first.
                cur_d   = (32'(cur_q) == NUM_VC_U - 32'd1) ? '0 : cur_q + 1'b1;
                state_d = SERVE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM, round pointer, credit and weight registers.
    always_ff @(posedge CLK_2MHz or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cur_q   <= '0;
            for (int i = 0; i < NUM_VC; i++) begin
                weight_q[i] <= WEIGHT_W'(DEFAULT_WEIGHT);
                credit_q[i] <= WEIGHT_W'(DEFAULT_WEIGHT);
            end
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            for (int i = 0; i < NUM_VC; i++) begin
                credit_q[i] <= credit_d[i];
                if (wr_ok && (vc_assign == VC_ID_W'(i))) begin
                    weight_q[i] <= weight_assign;
                end
            end
        end
    end

    // Registered output word: captured from the granted FIFO head on the pop edge.
    always_ff @(posedge CLK_2MHz or negedge reset) begin
        if (!reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            vc_q    <= '0;
            wout_q  <= '0;
        end else begin
            valid_q <= pop_en;
            if (pop_en) begin
                data_q <= data_in[int'(sel)*DATA_W +: DATA_W];
                vc_q   <= sel;
                wout_q <= weight_q[sel];
            end
        end
    end

    // One-cycle pulse for a rejected weight write.
    always_ff @(posedge CLK_2MHz or negedge reset) begin
        if (!reset) begin
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= wr_bad;
        end
    end

    // One-hot FIFO pop for the selected VC.
    always_comb begin
        pop = '0;
        if (pop_en) begin
            pop[sel] = 1'b1;
        end
    end

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign VC_id      = vc_q;
    assign weight     = wout_q;
    assign cfg_error  = cfg_err_q;
    assign idle       = (state_q == IDLE);
    assign fsm_state  = state_q;

`ifdef QOS_STATS_EN
    logic [7:0] stat_q [NUM_VC];

    // Saturating per-VC grant counters.
    always_ff @(posedge CLK_2MHz or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_VC; i++) begin
                stat_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_VC; i++) begin
                if (pop[i] && (stat_q[i] != 8'hFF)) begin
                    stat_q[i] <= stat_q[i] + 8'd1;
                end
            end
        end
    end

    // Counter read-back; an out-of-range selector reads as zero.
    always_comb begin
        stat_count = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            if (stat_sel == VC_ID_W'(i)) begin
                stat_count = stat_q[i];
            end
        end
    end
`endif

endmodule
